// File: rtl/rng_arbiter_pkg.sv
// Shared types and default sizing for the rng word arbiter.
package rng_arbiter_pkg;

  localparam int unsigned RNG_WIDTH   = 8;
  localparam int unsigned RNG_NUM_CLI = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT,
    ST_DELIVER,
    ST_FAULT
  } rng_arb_state_t;

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Shares one rng word source among NUM_CLI requesters with round-robin
// grant, stall watchdog and repeated-word health test.
module rng_arbiter
  import rng_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = RNG_WIDTH,
  parameter int unsigned NUM_CLI   = RNG_NUM_CLI,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned REP_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NUM_CLI-1:0] cli_req,
  output logic [NUM_CLI-1:0] cli_valid,
  output logic [WIDTH-1:0]   cli_word,
  output logic               rng_en,
  output logic               rng_req,
  input  logic [WIDTH-1:0]   rng_word,
  input  logic               rng_valid,
  input  logic               clear_err,
  output logic               err_timeout,
  output logic               err_health,
  output logic               busy
);

  localparam int unsigned IW = $clog2(NUM_CLI);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);

  rng_arb_state_t state_q, state_d;

  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    grant_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] last_q;
  logic [RW-1:0]    rep_cnt_q;
  logic [TW-1:0]    tmo_cnt_q;
  logic             err_timeout_q;
  logic             err_health_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [RW-1:0]    rep_next;
  logic             health_trip;
  logic             tmo_hit;

  rr_pick #(
    .N  (NUM_CLI),
    .IW (IW)
  ) u_pick (
    .req   (cli_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign rep_next    = (rng_word == last_q) ? rep_cnt_q + 1'b1 : RW'(1);
  assign health_trip = (rep_next == RW'(REP_LIMIT));
  assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; enable low freezes the FSM in place.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_IDLE:    if (|cli_req) state_d = ST_GRANT;
        ST_GRANT:   state_d = pick_found ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (rng_valid)    state_d = health_trip ? ST_FAULT : ST_DELIVER;
          else if (tmo_hit) state_d = ST_IDLE;
        end
        ST_DELIVER: state_d = ST_IDLE;
        ST_FAULT:   if (clear_err) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Grant, capture, watchdog counters and sticky error flags.
  // A set of err_timeout in WAIT is written after the clear so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      word_q        <= '0;
      last_q        <= '0;
      rep_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
      err_health_q  <= 1'b0;
    end else if (enable) begin
      if (clear_err) err_timeout_q <= 1'b0;
      case (state_q)
        ST_GRANT: begin
          if (pick_found) grant_q <= pick_idx;
          tmo_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (rng_valid) begin
            word_q    <= rng_word;
            last_q    <= rng_word;
            rep_cnt_q <= rep_next;
            if (health_trip) err_health_q <= 1'b1;
          end else if (tmo_hit) begin
            err_timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_DELIVER: begin
          rr_ptr_q <= (grant_q == IW'(NUM_CLI - 1)) ? '0 : grant_q + 1'b1;
        end
        ST_FAULT: begin
          if (clear_err) begin
            err_health_q <= 1'b0;
            rep_cnt_q    <= '0;
            last_q       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; delivery is gated by enable so a frozen
  // DELIVER never presents the same word twice.
  always_comb begin
    rng_req   = 1'b0;
    cli_valid = '0;
    cli_word  = '0;
    case (state_q)
      ST_WAIT:    rng_req = 1'b1;
      ST_DELIVER: begin
        if (enable && cli_req[grant_q]) begin
          cli_valid[grant_q] = 1'b1;
          cli_word           = word_q;
        end
      end
      default: ;
    endcase
  end

  assign rng_en      = enable & ~err_health_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_timeout_q;
  assign err_health  = err_health_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed and randomized bench for rng_arbiter against a transaction-level model.
module tb_rng_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int REP = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [N-1:0] cli_req;
  logic [N-1:0] cli_valid;
  logic [W-1:0] cli_word;
  logic         rng_en;
  logic         rng_req;
  logic [W-1:0] rng_word;
  logic         rng_valid;
  logic         clear_err;
  logic         err_timeout;
  logic         err_health;
  logic         busy;

  always #5 clk = ~clk;

  rng_arbiter #(
    .WIDTH     (W),
    .NUM_CLI   (N),
    .TIMEOUT   (TMO),
    .REP_LIMIT (REP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .cli_req     (cli_req),
    .cli_valid   (cli_valid),
    .cli_word    (cli_word),
    .rng_en      (rng_en),
    .rng_req     (rng_req),
    .rng_word    (rng_word),
    .rng_valid   (rng_valid),
    .clear_err   (clear_err),
    .err_timeout (err_timeout),
    .err_health  (err_health),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and repeated-word tracker.
  int           m_ptr;
  logic [W-1:0] m_last;
  int           m_rep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (((r >> j) & 4'b0001) != 4'b0000) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] fresh_word();
    logic [W-1:0] w;
    w = 8'($urandom_range(0, 255));
    while (w == m_last || w == 8'h3C || w == 8'h77) w = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // One request/grant/word/delivery round, entered and left on an IDLE negedge.
  task automatic do_txn(input logic [N-1:0] add, input bit keep, input bit drop,
                        input int d, input logic [W-1:0] w, input int frz);
    int           g;
    int           rep;
    logic [N-1:0] one;
    cli_req = cli_req | add;
    g = pick(cli_req, m_ptr);
    @(negedge clk);
    chk("grant_busy", 32'(busy), 1);
    chk("grant_no_rng_req", 32'(rng_req), 0);
    @(negedge clk);
    chk("wait_rng_req", 32'(rng_req), 1);
    if (frz > 0) begin
      enable = 1'b0;
      repeat (frz) begin
        @(negedge clk);
        chk("freeze_rng_en", 32'(rng_en), 0);
        chk("freeze_busy", 32'(busy), 1);
      end
      enable = 1'b1;
    end
    repeat (d) begin
      @(negedge clk);
      chk("wait_hold_req", 32'(rng_req), 1);
      chk("wait_no_valid", 32'(cli_valid), 0);
    end
    rng_valid = 1'b1;
    rng_word  = w;
    if (drop) cli_req = cli_req & ~(4'b0001 << g);
    @(negedge clk);
    rng_valid = 1'b0;
    rng_word  = 8'($urandom_range(0, 255));
    rep    = (w == m_last) ? m_rep + 1 : 1;
    m_last = w;
    m_rep  = rep;
    if (rep == REP) begin
      chk("health_no_valid", 32'(cli_valid), 0);
      chk("health_flag", 32'(err_health), 1);
      chk("health_rng_en", 32'(rng_en), 0);
      chk("health_rng_req", 32'(rng_req), 0);
      chk("health_busy", 32'(busy), 1);
      return;
    end
    one = drop ? 4'b0000 : (4'b0001 << g);
    chk("deliver_valid", 32'(cli_valid), 32'(one));
    chk("deliver_word", 32'(cli_word), drop ? 32'h0 : 32'(w));
    chk("deliver_rng_req", 32'(rng_req), 0);
    chk("deliver_no_health", 32'(err_health), 0);
    m_ptr = (g + 1) % N;
    @(negedge clk);
    chk("post_no_valid", 32'(cli_valid), 0);
    chk("post_idle", 32'(busy), 0);
    if (!keep && !drop) cli_req = cli_req & ~(4'b0001 << g);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    cli_req   = '0;
    rng_word  = '0;
    rng_valid = 1'b0;
    clear_err = 1'b0;
    m_ptr  = 0;
    m_last = '0;
    m_rep  = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_cli_valid", 32'(cli_valid), 0);
    chk("rst_cli_word", 32'(cli_word), 0);
    chk("rst_rng_req", 32'(rng_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
    chk("rst_err_health", 32'(err_health), 0);
    chk("rst_rng_en", 32'(rng_en), 1);
    reset_n = 1'b1;

    // All four clients held: rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      do_txn((i == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, $urandom_range(0, 8), fresh_word(), 0);
    cli_req = '0;
    @(negedge clk);

    // Single client 1, word after 16 WAIT cycles, then pointer lands at 2.
    do_txn(4'b0010, 1'b0, 1'b0, 16, 8'hA5, 0);
    do_txn(4'b0011, 1'b0, 1'b0, 2, fresh_word(), 0);
    do_txn(4'b0000, 1'b0, 1'b0, 1, fresh_word(), 0);

    // Randomized request patterns, delays and occasional drops.
    for (int i = 0; i < 14; i++)
      do_txn(4'($urandom_range(1, 15)), 1'b0, ($urandom_range(0, 5) == 0),
             $urandom_range(0, 20), fresh_word(), 0);
    cli_req = '0;
    @(negedge clk);

    // Word on the last permitted WAIT cycle still delivers.
    do_txn(4'b1000, 1'b0, 1'b0, TMO - 1, fresh_word(), 0);

    // Freeze longer than TIMEOUT mid-WAIT; counter holds, word delivers.
    do_txn(4'b0100, 1'b0, 1'b0, 40, fresh_word(), 80);

    // Stall: no rng_valid ever.
    cli_req = 4'b0100;
    @(negedge clk);
    chk("tmo_grant", 32'(busy), 1);
    @(negedge clk);
    chk("tmo_wait_entry", 32'(rng_req), 1);
    repeat (TMO - 1) begin
      @(negedge clk);
      chk("tmo_not_yet", 32'(err_timeout), 0);
      chk("tmo_still_req", 32'(rng_req), 1);
    end
    @(negedge clk);
    chk("tmo_flag", 32'(err_timeout), 1);
    chk("tmo_rng_req", 32'(rng_req), 0);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_no_valid", 32'(cli_valid), 0);
    cli_req = '0;
    @(negedge clk);
    chk("tmo_sticky", 32'(err_timeout), 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("tmo_cleared", 32'(err_timeout), 0);

    // Same word three times: two deliveries then health fault.
    do_txn(4'b0001, 1'b0, 1'b0, 3, 8'h3C, 0);
    do_txn(4'b0001, 1'b0, 1'b0, 3, 8'h3C, 0);
    do_txn(4'b0001, 1'b0, 1'b0, 3, 8'h3C, 0);
    cli_req = '0;
    @(negedge clk);
    chk("fault_hold_busy", 32'(busy), 1);
    chk("fault_hold_rng_en", 32'(rng_en), 0);
    chk("fault_hold_rng_req", 32'(rng_req), 0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("fault_clr_health", 32'(err_health), 0);
    chk("fault_clr_rng_en", 32'(rng_en), 1);
    chk("fault_clr_idle", 32'(busy), 0);
    m_rep  = 0;
    m_last = '0;

    // rng_valid in IDLE must not be captured into the repeat tracker.
    rng_valid = 1'b1;
    rng_word  = 8'h77;
    @(negedge clk);
    rng_valid = 1'b0;
    chk("idle_valid_ignored", 32'(busy), 0);
    chk("idle_valid_no_cli", 32'(cli_valid), 0);
    do_txn(4'b0001, 1'b0, 1'b0, 2, 8'h77, 0);
    do_txn(4'b0001, 1'b0, 1'b0, 2, 8'h77, 0);

    // Client 1 drops during WAIT: nothing delivered, pointer moves to 2.
    do_txn(4'b0010, 1'b0, 1'b1, 5, fresh_word(), 0);
    do_txn(4'b0110, 1'b0, 1'b0, 1, fresh_word(), 0);
    do_txn(4'b0000, 1'b0, 1'b0, 1, fresh_word(), 0);

    // Asynchronous reset in the middle of WAIT.
    cli_req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_wait", 32'(rng_req), 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_rng_req", 32'(rng_req), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_cli_valid", 32'(cli_valid), 0);
    chk("rstw_cli_word", 32'(cli_word), 0);
    chk("rstw_err_timeout", 32'(err_timeout), 0);
    chk("rstw_err_health", 32'(err_health), 0);
    cli_req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr  = 0;
    m_last = '0;
    m_rep  = 0;
    do_txn(4'b1111, 1'b0, 1'b0, 4, fresh_word(), 0);
    cli_req = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
